// File: rtl/lamp_pkg.sv
// Colour codes, FSM states, fault causes and the colour successor rule shared by
// the lamp sequencer and the lamp output driver.
package lamp_pkg;

  localparam logic [2:0] ColRed    = 3'b000;
  localparam logic [2:0] ColGreen  = 3'b001;
  localparam logic [2:0] ColYellow = 3'b010;

  localparam logic [1:0] FaultNone    = 2'b00;
  localparam logic [1:0] FaultIllegal = 2'b01;
  localparam logic [1:0] FaultSeq     = 2'b10;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StFault
  } state_e;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == ColRed) || (c == ColGreen) || (c == ColYellow);
  endfunction

  // GREEN -> YELLOW -> RED -> GREEN; only meaningful for legal codes.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    logic [2:0] n;
    n = ColGreen;
    case (c)
      ColGreen:  n = ColYellow;
      ColYellow: n = ColRed;
      default:   n = ColGreen;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lamp_output_driver_if.sv
// Sequencer-to-driver link: colour code, brightness and fault clear in,
// lamp drives and fault status back.
interface lamp_output_driver_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic [2:0]          light;
  logic [PWM_BITS-1:0] duty;
  logic                fault_clr;
  logic                lamp_r;
  logic                lamp_y;
  logic                lamp_g;
  logic                fault;
  logic [1:0]          fault_code;

  modport master (
    output light, duty, fault_clr,
    input  lamp_r, lamp_y, lamp_g, fault, fault_code
  );

  modport slave (
    input  light, duty, fault_clr,
    output lamp_r, lamp_y, lamp_g, fault, fault_code
  );
endinterface

// File: rtl/lamp_pwm.sv
// Free-running PWM counter and duty compare; all-ones duty means always on.
module lamp_pwm #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pwm_on = (&duty) || (cnt_q < duty);

endmodule

// File: rtl/lamp_output_driver.sv
// Lamp output stage: registers the colour code, checks legality and sequence order,
// and drives one-hot PWM-dimmed lamps or fail-safe flashing red on a fault.
module lamp_output_driver
  import lamp_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FLASH_HALF = 4
) (
  input logic               clk,
  input logic               rst_n,
  lamp_output_driver_if.slave bus
);

  localparam int unsigned FlashW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_HALF - 1);

  logic [2:0]        code_q;
  logic              code_v_q;
  state_e            state_q, state_d;
  logic [2:0]        cur_col_q, cur_col_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic              flash_phase_q, flash_phase_d;
  logic              lamp_r_q, lamp_y_q, lamp_g_q, fault_q;
  logic              lamp_r_d, lamp_y_d, lamp_g_d;
  logic              pwm_on;

  lamp_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .duty  (bus.duty),
    .pwm_on(pwm_on)
  );

  always_comb begin
    state_d       = state_q;
    cur_col_d     = cur_col_q;
    fault_code_d  = fault_code_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;

    unique case (state_q)
      StInit: begin
        if (code_v_q) begin
          if (is_legal(code_q)) begin
            state_d   = StRun;
            cur_col_d = code_q;
          end else begin
            state_d      = StFault;
            fault_code_d = FaultIllegal;
          end
        end
      end
      StRun: begin
        if (!is_legal(code_q)) begin
          state_d      = StFault;
          fault_code_d = FaultIllegal;
        end else if (code_q == cur_col_q || code_q == next_colour(cur_col_q)) begin
          cur_col_d = code_q;
        end else begin
          state_d      = StFault;
          fault_code_d = FaultSeq;
        end
      end
      StFault: begin
        if (bus.fault_clr && code_q == ColRed) begin
          state_d      = StRun;
          cur_col_d    = ColRed;
          fault_code_d = FaultNone;
        end else if (flash_cnt_q == FlashLast) begin
          flash_cnt_d   = '0;
          flash_phase_d = ~flash_phase_q;
        end else begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
      end
      default: state_d = StInit;
    endcase

    // Flashing always starts with the lamp lit.
    if (state_q != StFault && state_d == StFault) begin
      flash_cnt_d   = '0;
      flash_phase_d = 1'b1;
    end
  end

  // Lamps are decoded from next state so they move on the same edge as the FSM.
  always_comb begin
    lamp_r_d = 1'b0;
    lamp_y_d = 1'b0;
    lamp_g_d = 1'b0;
    unique case (state_d)
      StInit:  lamp_r_d = pwm_on;
      StRun: begin
        lamp_r_d = pwm_on && (cur_col_d == ColRed);
        lamp_y_d = pwm_on && (cur_col_d == ColYellow);
        lamp_g_d = pwm_on && (cur_col_d == ColGreen);
      end
      StFault: lamp_r_d = flash_phase_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q        <= ColRed;
      code_v_q      <= 1'b0;
      state_q       <= StInit;
      cur_col_q     <= ColRed;
      fault_code_q  <= FaultNone;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      lamp_r_q      <= 1'b0;
      lamp_y_q      <= 1'b0;
      lamp_g_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      code_q        <= bus.light;
      code_v_q      <= 1'b1;
      state_q       <= state_d;
      cur_col_q     <= cur_col_d;
      fault_code_q  <= fault_code_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      lamp_r_q      <= lamp_r_d;
      lamp_y_q      <= lamp_y_d;
      lamp_g_q      <= lamp_g_d;
      fault_q       <= (state_d == StFault);
    end
  end

  assign bus.lamp_r     = lamp_r_q;
  assign bus.lamp_y     = lamp_y_q;
  assign bus.lamp_g     = lamp_g_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_lamp_output_driver.sv
// Directed bench for lamp_output_driver with a cycle-level reference model
// and per-cycle output comparison.
module tb_lamp_output_driver;
  import lamp_pkg::*;

  localparam int unsigned FH = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  lamp_output_driver_if #(.PWM_BITS(8)) bus ();

  lamp_output_driver #(
    .PWM_BITS  (8),
    .FLASH_HALF(FH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting for first code, 1 = running, 2 = faulted.
  int         m_mode  = 0;
  logic [2:0] m_col   = 3'b000;
  logic [2:0] m_cap   = 3'b000;
  bit         m_have  = 0;
  int         m_cause = 0;
  int         m_age   = 0;
  int         m_edges = 0;
  bit         exp_r = 0, exp_y = 0, exp_g = 0, exp_f = 0;
  int         exp_code = 0;

  function automatic bit legal(input logic [2:0] c);
    return c <= 3'd2;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    logic [2:0] order [3];
    logic [2:0] r;
    order = '{3'b001, 3'b010, 3'b000};  // green, yellow, red
    r = order[0];
    for (int i = 0; i < 3; i++) if (order[i] == c) r = order[(i + 1) % 3];
    return r;
  endfunction

  task automatic model_fault(input int cause);
    m_mode  = 2;
    m_cause = cause;
    m_age   = 0;
  endtask

  task automatic model_step();
    bit pwm;
    if (!rst_n) begin
      m_mode = 0; m_col = 3'b000; m_cap = 3'b000; m_have = 0; m_cause = 0;
      m_age = 0; m_edges = 0; exp_r = 0; exp_y = 0; exp_g = 0; exp_f = 0; exp_code = 0;
      return;
    end
    pwm = (bus.duty == 8'hFF) || ((m_edges % 256) < int'(bus.duty));
    if (m_mode == 2) begin
      if (bus.fault_clr && m_cap == 3'b000) begin
        m_mode = 1; m_col = 3'b000; m_cause = 0;
      end else begin
        m_age++;
      end
    end else if (m_have) begin
      if (!legal(m_cap)) model_fault(1);
      else if (m_mode == 0 || m_cap == m_col || m_cap == succ(m_col)) begin
        m_mode = 1; m_col = m_cap;
      end else model_fault(2);
    end
    exp_r = 0; exp_y = 0; exp_g = 0;
    if (m_mode == 0) exp_r = pwm;
    else if (m_mode == 1) begin
      exp_r = pwm && m_col == 3'b000;
      exp_g = pwm && m_col == 3'b001;
      exp_y = pwm && m_col == 3'b010;
    end else exp_r = ((m_age / FH) % 2) == 0;
    exp_f    = (m_mode == 2);
    exp_code = m_cause;
    m_cap  = bus.light;
    m_have = 1;
    m_edges++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("lamp_r", int'(bus.lamp_r), int'(exp_r));
    check("lamp_y", int'(bus.lamp_y), int'(exp_y));
    check("lamp_g", int'(bus.lamp_g), int'(exp_g));
    check("fault", int'(bus.fault), int'(exp_f));
    check("fault_code", int'(bus.fault_code), exp_code);
    check("one_hot", int'(bus.lamp_r) + int'(bus.lamp_y) + int'(bus.lamp_g) <= 1 ? 1 : 0, 1);
  end

  task automatic step(input logic [2:0] l, input logic clr);
    @(negedge clk);
    bus.light     = l;
    bus.fault_clr = clr;
  endtask

  int         cnt;
  logic [7:0] pat;
  logic [2:0] seq [3];

  initial begin
    seq = '{ColGreen, ColYellow, ColRed};
    bus.light = ColRed; bus.duty = 8'hFF; bus.fault_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_lamp_r", int'(bus.lamp_r), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_code", int'(bus.fault_code), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(seq[i % 3], 1'b0);
    @(negedge clk); check("seq_lamp_y", int'(bus.lamp_y), 1);
    @(negedge clk); check("seq_lamp_r", int'(bus.lamp_r), 1);
    check("seq_no_fault", int'(bus.fault), 0);

    bus.light = ColGreen; bus.duty = 8'd64;
    @(negedge clk);
    cnt = 0;
    repeat (256) begin @(negedge clk); cnt += int'(bus.lamp_g); end
    check("duty64_count", cnt, 64);
    bus.duty = 8'd0;
    cnt = 0;
    repeat (256) begin @(negedge clk); cnt += int'(bus.lamp_g); end
    check("duty0_count", cnt, 0);

    bus.duty = 8'hFF; bus.light = 3'b011;
    @(negedge clk); bus.light = ColGreen;
    @(negedge clk);
    check("illegal_fault", int'(bus.fault), 1);
    check("illegal_code", int'(bus.fault_code), 1);
    pat[0] = bus.lamp_r;
    for (int k = 1; k < 8; k++) begin @(negedge clk); pat[k] = bus.lamp_r; end
    check("flash_pattern", int'(pat), 8'h0F);

    bus.fault_clr = 1'b1;
    @(negedge clk); bus.fault_clr = 1'b0; bus.light = ColRed;
    @(negedge clk); check("clr_green_ignored", int'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    @(negedge clk); bus.fault_clr = 1'b0;
    check("clr_exit_fault", int'(bus.fault), 0);
    check("clr_exit_code", int'(bus.fault_code), 0);
    check("clr_exit_red", int'(bus.lamp_r), 1);
    bus.light = ColGreen;
    @(negedge clk);
    @(negedge clk); check("after_clr_green", int'(bus.lamp_g), 1);

    bus.light = ColRed;
    @(negedge clk); bus.light = ColGreen;
    @(negedge clk);
    check("skip_code", int'(bus.fault_code), 2);
    bus.light = 3'b111;
    @(negedge clk); bus.light = ColGreen;
    @(negedge clk); check("sticky_code", int'(bus.fault_code), 2);

    #1 rst_n = 1'b0;
    #1;
    check("async_lamp_r", int'(bus.lamp_r), 0);
    check("async_lamp_y", int'(bus.lamp_y), 0);
    check("async_lamp_g", int'(bus.lamp_g), 0);
    check("async_fault", int'(bus.fault), 0);
    check("async_code", int'(bus.fault_code), 0);
    bus.light = ColYellow;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_yellow", int'(bus.lamp_y), 1);
    check("restart_no_fault", int'(bus.fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lamp_output_driver.md
# lamp_output_driver

- Downstream stage of the cyclic lamp sequencer: consumes the 3-bit colour code and drives three one-hot lamp outputs (red/yellow/green) with PWM dimming.
- Checks that every code is legal and that colours advance only GREEN→YELLOW→RED→GREEN.
- On any violation it latches a fault and forces fail-safe flashing red until cleared.

## Interface
- PWM_BITS, 8: width of PWM counter and duty input.
- FLASH_HALF, 4: clock cycles per half-period of fault flashing (≥1).
- clk  in  1  single clock, all flops on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- light  in  3  colour code from sequencer: 000 RED, 001 GREEN, 010 YELLOW; all other values illegal.
- duty  in  PWM_BITS  lamp brightness; sampled every cycle.
- fault_clr  in  1  single-cycle request to leave FAULT.
- lamp_r, lamp_y, lamp_g  out  1 each  lamp drives; at most one high in any cycle.
- fault  out  1  high while in FAULT.
- fault_code  out  2  00 none, 01 illegal code, 10 illegal transition; sticky, holds the first cause.

## Operation
- Input stage: light is registered into code_q every cycle. Reset value of code_q is RED; code_v resets to 0 and sets after the first post-reset edge.
- States: INIT, RUN, FAULT. Reset state is INIT.
- INIT:
  - Lamps show steady red (lamp_r = pwm_on).
  - Once code_v=1, a legal code_q becomes cur_col and the FSM goes to RUN. No transition check applies to this first code.
  - An illegal code_q goes to FAULT with code 01.
- RUN:
  - cur_col ← code_q when code_q equals cur_col or is its successor (GREEN→YELLOW, YELLOW→RED, RED→GREEN).
  - Illegal code → FAULT, fault_code 01.
  - Legal code that is neither hold nor successor → FAULT, fault_code 10, cur_col unchanged.
  - Lamp matching cur_col = pwm_on; other two lamps 0.
- FAULT:
  - lamp_y = lamp_g = 0; lamp_r = flash_phase at full brightness, ignoring duty. fault = 1.
  - On entry: flash_cnt = 0, flash_phase = 1.
  - flash_cnt counts 0..FLASH_HALF-1; flash_phase toggles on wrap.
- Fault exit:
  - fault_clr=1 while code_q==RED → RUN with cur_col=RED; fault and fault_code clear on the same edge.
  - fault_clr with any other code_q is ignored. fault_clr outside FAULT is ignored.
  - Further violations while in FAULT do not change fault_code.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, wraps 2^PWM_BITS-1 → 0.
  - pwm_on = 1 if duty is all-ones, else (pwm_cnt < duty).
  - duty=0 → lamps always off in INIT/RUN.
- Reset (asynchronous, any time, including mid-FAULT) forces all lamps 0, fault 0, fault_code 00, pwm_cnt 0, flash counters 0, state INIT, cur_col RED.

## Timing
- Latency: light valid before edge N → code_q at N → state, cur_col and lamps updated at edge N+1. Two-edge input-to-lamp latency.
- Lamp outputs, fault and fault_code are registered; no combinational path from inputs to outputs.
- Fault detection is visible on the lamps at the same edge as fault=1 (N+1).
- A new legal colour every cycle (upstream advancing each clock) must be accepted with no stall or bubble.
- fault_clr is evaluated at edge N+1 against the code_q captured at edge N.
- PWM compare uses the current pwm_cnt and duty; a duty change takes effect on the next registered lamp update.

## Structure
- Shared package lamp_pkg:
  - colour code constants RED/GREEN/YELLOW;
  - FSM state type (INIT/RUN/FAULT);
  - fault code constants;
  - successor function next_colour().
- The upstream sequencer uses the same colour constants.
- Sub-module lamp_pwm: pwm_cnt plus compare, producing pwm_on. Parameterised by PWM_BITS.
- Top level holds the input register, FSM, sequence checker, flash timer and output decode.

## Test plan
- Reset, then cycle GREEN,YELLOW,RED,GREEN… one per clock with duty=all-ones → matching lamp high two edges after each code; fault stays 0.
- duty=64 (PWM_BITS=8) with steady GREEN → lamp_g high exactly 64 of every 256 cycles; duty=0 → lamp_g never high.
- Inject light=011 in RUN → fault=1, fault_code=01 one edge after capture; lamp_r toggles every 4 cycles starting high; lamp_y=lamp_g=0.
- GREEN then RED (skipped YELLOW) → fault_code=10. Then an illegal code → fault_code stays 10.
- In FAULT: fault_clr with code GREEN → no exit. fault_clr with code RED → next edge RUN, fault=0, lamp_r=pwm_on; the following GREEN is accepted.
- Assert rst_n low mid-flash → all outputs 0 immediately, without waiting for a clock edge. After release, first legal code is adopted from INIT without fault.
